aoi_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one AND-OR evaluation unit among N requesters. The unit computes out = (a&b)|(c&d) and out_n = ~out. Each cycle the block grants at most one requester, captures its 4-bit operand, and presents a registered result tagged with the requester id on a valid/ready output port. It sits between several operand producers and one result consumer in the lab datapath.

---
 rtl/aoi_rr_scheduler_pkg.sv | 23 ++
 rtl/aoi_rr_scheduler_if.sv | 28 ++
 rtl/aoi_rr_scheduler_rr_pick.sv | 32 +++
 rtl/aoi_rr_scheduler.sv | 80 ++++++++
 tb/tb_aoi_rr_scheduler.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/aoi_rr_scheduler_pkg.sv
// Shared definitions for the AND-OR round-robin scheduler: operand layout,
// result-register state and the evaluation helper.
package aoi_rr_scheduler_pkg;

  // Operand is {a,b,c,d}, MSB to LSB
  localparam int OPND_W = 4;
  localparam int OP_A   = 3;
  localparam int OP_B   = 2;
  localparam int OP_C   = 1;
  localparam int OP_D   = 0;

  // Result register occupancy
  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  // (a&b)|(c&d) of one operand
  function automatic logic aoi_eval(input logic [OPND_W-1:0] op);
    return (op[OP_A] & op[OP_B]) | (op[OP_C] & op[OP_D]);
  endfunction

endpackage

// File: rtl/aoi_rr_scheduler_if.sv
// Requester/result bus of the scheduler. The slave side is the scheduler,
// the master side is the producers plus the result consumer.
interface aoi_rr_scheduler_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);
  import aoi_rr_scheduler_pkg::*;

  logic [N-1:0]        req;
  logic [OPND_W*N-1:0] opnd;
  logic [N-1:0]        gnt;
  logic                res_valid;
  logic                res_ready;
  logic [ID_W-1:0]     res_id;
  logic                res_out;
  logic                res_out_n;

  modport slave (
    input  req, opnd, res_ready,
    output gnt, res_valid, res_id, res_out, res_out_n
  );

  modport master (
    output req, opnd, res_ready,
    input  gnt, res_valid, res_id, res_out, res_out_n
  );

endinterface

// File: rtl/aoi_rr_scheduler_rr_pick.sv
// Combinational round-robin selector: first set req bit starting at ptr and
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_oh,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    int idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = ID_W'(idx);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aoi_rr_scheduler.sv
// Round-robin scheduler sharing one AND-OR evaluation unit among N
// requesters; one result register with valid/ready output handshake.
module aoi_rr_scheduler
  import aoi_rr_scheduler_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input logic               clk,
  input logic               reset,
  aoi_rr_scheduler_if.slave bus
);

  res_state_e          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     res_id_q;
  logic                res_out_q;
  logic                res_out_n_q;

  logic [N-1:0]        pick_oh;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                can_issue;
  logic                grant;
  logic [OPND_W-1:0]   sel_opnd;
  logic                eval;

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // A slot is free when the register is empty or being drained this cycle
  assign can_issue = (state == RES_EMPTY) | bus.res_ready;
  assign grant     = can_issue & pick_any & ~reset;
  assign bus.gnt   = grant ? pick_oh : '0;

  // Operand mux driven by the selected requester index
  always_comb begin
    sel_opnd = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_opnd = bus.opnd[i*OPND_W +: OPND_W];
      end
    end
  end

  assign eval = aoi_eval(sel_opnd);

  // Result register and pointer: capture on grant, drain on accept, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RES_EMPTY;
      rr_ptr      <= '0;
      res_id_q    <= '0;
      res_out_q   <= 1'b0;
      res_out_n_q <= 1'b0;
    end else if (grant) begin
      state       <= RES_FULL;
      res_id_q    <= pick_idx;
      res_out_q   <= eval;
      res_out_n_q <= ~eval;
      rr_ptr      <= (pick_idx == ID_W'(N - 1)) ? '0 : pick_idx + 1'b1;
    end else if ((state == RES_FULL) && bus.res_ready) begin
      state <= RES_EMPTY;
    end
  end

  assign bus.res_valid = (state == RES_FULL);
  assign bus.res_id    = res_id_q;
  assign bus.res_out   = res_out_q;
  assign bus.res_out_n = res_out_n_q;

endmodule

// File: tb/tb_aoi_rr_scheduler.sv
// Self-checking bench for aoi_rr_scheduler: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the scheduler.
module tb_aoi_rr_scheduler;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic clk;
  logic reset;

  aoi_rr_scheduler_if #(.N(N), .ID_W(ID_W)) bus ();

  aoi_rr_scheduler #(.N(N), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_bad;

  // Inputs applied this cycle
  logic           cur_rst;
  logic [N-1:0]   cur_req;
  logic [4*N-1:0] cur_opnd;
  logic           cur_ready;

  // Behavioural model state
  int   m_ptr;
  bit   m_valid;
  int   m_id;
  bit   m_out;
  bit   m_out_n;

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester chosen this cycle by the round-robin rule, -1 for none
  function automatic int model_pick();
    if (cur_rst) return -1;
    if (m_valid && !cur_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (cur_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_aoi(input int i);
    logic [3:0] nib;
    nib = cur_opnd[4*i +: 4];
    return (nib[3] & nib[2]) | (nib[1] & nib[0]);
  endfunction

  task automatic check_output();
    int p;
    logic [N-1:0] exp_gnt;
    p = model_pick();
    exp_gnt = '0;
    if (p >= 0) exp_gnt[p] = 1'b1;
    expect_val("gnt",       32'(bus.gnt),       32'(exp_gnt));
    expect_val("res_valid", 32'(bus.res_valid), 32'(m_valid));
    expect_val("res_id",    32'(bus.res_id),    32'(m_id));
    expect_val("res_out",   32'(bus.res_out),   32'(m_out));
    expect_val("res_out_n", 32'(bus.res_out_n), 32'(m_out_n));
  endtask

  // Advance the model to what the coming rising edge produces
  task automatic model_step();
    int p;
    p = model_pick();
    if (cur_rst) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_out = 0; m_out_n = 0;
    end else if (p >= 0) begin
      m_valid = 1;
      m_id    = p;
      m_out   = model_aoi(p);
      m_out_n = !m_out;
      m_ptr   = (p + 1) % N;
    end else if (m_valid && cur_ready) begin
      m_valid = 0;
    end
  endtask

  // One cycle: drive on the falling edge, check 1 time unit later, then advance model
  task automatic apply_stimulus(input logic rst_v, input logic [N-1:0] req_v,
                                input logic [4*N-1:0] opnd_v, input logic ready_v);
    @(negedge clk);
    cur_rst = rst_v; cur_req = req_v; cur_opnd = opnd_v; cur_ready = ready_v;
    reset = rst_v; bus.req = req_v; bus.opnd = opnd_v; bus.res_ready = ready_v;
    #1;
    check_output();
    model_step();
  endtask

  initial begin
    n_checks = 0; n_bad = 0;
    reset = 1'b1; bus.req = '0; bus.opnd = '0; bus.res_ready = 1'b1;
    cur_rst = 1'b1; cur_req = '0; cur_opnd = '0; cur_ready = 1'b1;
    m_ptr = 0; m_valid = 0; m_id = 0; m_out = 0; m_out_n = 0;
    repeat (2) @(posedge clk);

    // Reset with all requests held
    apply_stimulus(1, 4'b1111, 16'h0000, 1);
    expect_val("rst_gnt", 32'(bus.gnt), 32'h0);
    expect_val("rst_valid", 32'(bus.res_valid), 32'h0);
    apply_stimulus(0, 4'b1111, 16'h0000, 1);
    expect_val("first_gnt", 32'(bus.gnt), 32'b0001);
    apply_stimulus(0, 4'b0000, 16'h0000, 1);
    expect_val("first_id", 32'(bus.res_id), 32'h0);
    expect_val("first_valid", 32'(bus.res_valid), 32'h1);

    // Back-to-back rotation from pointer 0
    apply_stimulus(1, 4'b0000, 16'h0000, 1);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(0, 4'b1111, 16'hFFFF, 1);
      expect_val("rot_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
      if (k > 0) begin
        expect_val("rot_id", 32'(bus.res_id), 32'((k - 1) % 4));
        expect_val("rot_valid", 32'(bus.res_valid), 32'h1);
      end
    end

    // Operand evaluation on requester 2
    apply_stimulus(0, 4'b0100, 16'h0C00, 1);
    expect_val("op1_gnt", 32'(bus.gnt), 32'b0100);
    apply_stimulus(0, 4'b0000, 16'h0000, 1);
    expect_val("op1_out", 32'(bus.res_out), 32'h1);
    expect_val("op1_out_n", 32'(bus.res_out_n), 32'h0);
    expect_val("op1_id", 32'(bus.res_id), 32'h2);
    apply_stimulus(0, 4'b0100, 16'h0A00, 1);
    apply_stimulus(0, 4'b0000, 16'h0000, 0);
    expect_val("op2_out", 32'(bus.res_out), 32'h0);
    expect_val("op2_out_n", 32'(bus.res_out_n), 32'h1);

    // Backpressure for 3 cycles, then drain and grant on the same edge
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 4'b0011, 16'hFFFF, 0);
      expect_val("bp_gnt", 32'(bus.gnt), 32'h0);
      expect_val("bp_id", 32'(bus.res_id), 32'h2);
      expect_val("bp_out", 32'(bus.res_out), 32'h0);
    end
    apply_stimulus(0, 4'b0011, 16'hFFFF, 1);
    expect_val("bp_rel_gnt", 32'(bus.gnt), 32'b0001);
    apply_stimulus(0, 4'b0000, 16'h0000, 1);
    expect_val("bp_rel_id", 32'(bus.res_id), 32'h0);
    expect_val("bp_rel_valid", 32'(bus.res_valid), 32'h1);

    // Wrap fairness: move pointer to 3, then alternate between 3 and 0
    apply_stimulus(0, 4'b0100, 16'h0000, 1);
    apply_stimulus(0, 4'b1001, 16'h0000, 1);
    expect_val("wrap_gnt0", 32'(bus.gnt), 32'b1000);
    apply_stimulus(0, 4'b1001, 16'h0000, 1);
    expect_val("wrap_gnt1", 32'(bus.gnt), 32'b0001);
    apply_stimulus(0, 4'b1001, 16'h0000, 1);
    expect_val("wrap_gnt2", 32'(bus.gnt), 32'b1000);

    // Reset while a result is stalled
    apply_stimulus(0, 4'b0000, 16'h0000, 0);
    expect_val("mid_valid", 32'(bus.res_valid), 32'h1);
    apply_stimulus(1, 4'b1111, 16'h0000, 0);
    expect_val("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    apply_stimulus(0, 4'b1000, 16'h0000, 1);
    expect_val("mid_after_valid", 32'(bus.res_valid), 32'h0);
    expect_val("mid_after_gnt", 32'(bus.gnt), 32'b1000);
    apply_stimulus(0, 4'b1111, 16'h0000, 1);
    expect_val("mid_ptr_wrap", 32'(bus.gnt), 32'b0001);

    // Randomized traffic checked against the model
    for (int k = 0; k < 800; k++) begin
      apply_stimulus(($urandom_range(0, 63) == 0),
                     N'($urandom()),
                     (4*N)'($urandom()),
                     ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
